// File: rtl/lcd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lcd_scheduler
// Purpose  : Round-robin VRAM write arbiter for two ports plus panel refresh
//            sequencing; LCD_SCHED_AUTOREFRESH_EN adds a dirty-frame timer.
// Revision : 1.0
// ============================================================================
module lcd_scheduler #(
    parameter int unsigned REFRESH_PERIOD = 5000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        I_req0,
    input  logic        I_req1,
    input  logic [6:0]  I_row0,
    input  logic [6:0]  I_row1,
    input  logic [1:0]  I_col0,
    input  logic [1:0]  I_col1,
    input  logic [31:0] I_data0,
    input  logic [31:0] I_data1,
    input  logic        I_flush,
    input  logic [1:0]  I_lcd_status,
    output logic        O_ack0,
    output logic        O_ack1,
    output logic        O_vram_we,
    output logic [6:0]  O_row,
    output logic [1:0]  O_col,
    output logic [31:0] O_data,
    output logic        O_refresh,
    output logic        O_busy,
    output logic [15:0] O_frame_cnt
);

    typedef enum logic [1:0] {
        S_WAIT_INIT = 2'd0,
        S_IDLE      = 2'd1,
        S_REFRESH   = 2'd2,
        S_DRAIN     = 2'd3
    } state_t;

    localparam logic [1:0] c_st_init   = 2'd0;
    localparam logic [1:0] c_st_ready  = 2'd1;
    localparam logic [1:0] c_st_finish = 2'd3;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_pending;
    logic        w_pending_nxt;
    logic        r_dirty;
    logic        w_dirty_nxt;
    logic        r_rr;
    logic        w_rr_nxt;
    logic        w_ack0_nxt;
    logic        w_ack1_nxt;
    logic        w_we_nxt;
    logic        w_refresh_nxt;
    logic [6:0]  w_row_nxt;
    logic [1:0]  w_col_nxt;
    logic [31:0] w_data_nxt;
    logic [15:0] w_frame_nxt;
    logic        w_grant1;
    logic        w_refresh_start;
    logic        w_auto_set;

    assign w_refresh_start = (r_state == S_IDLE) && (I_lcd_status == c_st_ready) && r_pending;

`ifdef LCD_SCHED_AUTOREFRESH_EN
    localparam int unsigned c_tmr_w = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(REFRESH_PERIOD - 1);

    logic [c_tmr_w-1:0] r_timer;
    logic               w_timer_wrap;

    assign w_timer_wrap = (r_state == S_IDLE) && !w_refresh_start && (r_timer == c_tmr_last);
    assign w_auto_set   = w_timer_wrap && r_dirty;

    // Counts only while idle; a starting refresh restarts the interval.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_timer <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_refresh_start || w_timer_wrap)
                r_timer <= '0;
            else
                r_timer <= r_timer + c_tmr_w'(1);
        end
    end
`else
    localparam int unsigned c_unused_period = REFRESH_PERIOD;
    assign w_auto_set = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending | I_flush | w_auto_set;
        w_dirty_nxt   = r_dirty;
        w_rr_nxt      = r_rr;
        w_ack0_nxt    = 1'b0;
        w_ack1_nxt    = 1'b0;
        w_we_nxt      = 1'b0;
        w_refresh_nxt = O_refresh;
        w_row_nxt     = O_row;
        w_col_nxt     = O_col;
        w_data_nxt    = O_data;
        w_frame_nxt   = O_frame_cnt;
        w_grant1      = 1'b0;

        if (I_lcd_status == c_st_init) begin
            w_state_nxt   = S_WAIT_INIT;
            w_refresh_nxt = 1'b0;
        end else begin
            case (r_state)
                S_WAIT_INIT: begin
                    if (I_lcd_status == c_st_ready)
                        w_state_nxt = S_IDLE;
                end
                S_IDLE: begin
                    if (w_refresh_start) begin
                        // A flush landing on the start cycle is kept for the next frame.
                        w_refresh_nxt = 1'b1;
                        w_pending_nxt = I_flush;
                        w_dirty_nxt   = 1'b0;
                        w_state_nxt   = S_REFRESH;
                    end else if ((I_lcd_status == c_st_ready) && (I_req0 || I_req1) &&
                                 !O_ack0 && !O_ack1) begin
                        w_grant1    = I_req1 && (!I_req0 || r_rr);
                        w_rr_nxt    = !w_grant1;
                        w_ack0_nxt  = !w_grant1;
                        w_ack1_nxt  = w_grant1;
                        w_we_nxt    = 1'b1;
                        w_dirty_nxt = 1'b1;
                        w_row_nxt   = w_grant1 ? I_row1  : I_row0;
                        w_col_nxt   = w_grant1 ? I_col1  : I_col0;
                        w_data_nxt  = w_grant1 ? I_data1 : I_data0;
                    end
                end
                S_REFRESH: begin
                    if (I_lcd_status == c_st_finish) begin
                        w_refresh_nxt = 1'b0;
                        w_state_nxt   = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (I_lcd_status == c_st_ready) begin
                        w_frame_nxt = O_frame_cnt + 16'd1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_WAIT_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_WAIT_INIT;
            r_pending   <= 1'b0;
            r_dirty     <= 1'b0;
            r_rr        <= 1'b0;
            O_ack0      <= 1'b0;
            O_ack1      <= 1'b0;
            O_vram_we   <= 1'b0;
            O_row       <= '0;
            O_col       <= '0;
            O_data      <= '0;
            O_refresh   <= 1'b0;
            O_busy      <= 1'b0;
            O_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_dirty     <= w_dirty_nxt;
            r_rr        <= w_rr_nxt;
            O_ack0      <= w_ack0_nxt;
            O_ack1      <= w_ack1_nxt;
            O_vram_we   <= w_we_nxt;
            O_row       <= w_row_nxt;
            O_col       <= w_col_nxt;
            O_data      <= w_data_nxt;
            O_refresh   <= w_refresh_nxt;
            O_busy      <= (w_state_nxt != S_IDLE);
            O_frame_cnt <= w_frame_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_scheduler
// Purpose  : Scoreboard bench for lcd_scheduler with random port traffic.
// Revision : 1.0
// ============================================================================
module tb_lcd_scheduler;

    typedef struct packed {
        logic [6:0]  row;
        logic [1:0]  col;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [6:0]  row0 = '0, row1 = '0;
    logic [1:0]  col0 = '0, col1 = '0;
    logic [31:0] data0 = '0, data1 = '0;
    logic        flush = 1'b0;
    logic [1:0]  status = 2'd0;
    logic        ack0, ack1, we, refresh, busy;
    logic [6:0]  o_row;
    logic [1:0]  o_col;
    logic [31:0] o_data;
    logic [15:0] frame;

    int   total = 0;
    int   bad = 0;
    int   ack_cnt = 0;
    int   n_todo[2];
    int   gap_pct[2];
    txn_t q0[$];
    txn_t q1[$];

    lcd_scheduler #(.REFRESH_PERIOD(100)) dut (
        .clk(clk), .rstn(rstn),
        .I_req0(req0), .I_req1(req1),
        .I_row0(row0), .I_row1(row1),
        .I_col0(col0), .I_col1(col1),
        .I_data0(data0), .I_data1(data1),
        .I_flush(flush), .I_lcd_status(status),
        .O_ack0(ack0), .O_ack1(ack1), .O_vram_we(we),
        .O_row(o_row), .O_col(o_col), .O_data(o_data),
        .O_refresh(refresh), .O_busy(busy), .O_frame_cnt(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input int p, input logic r, input txn_t t);
        if (p == 0) begin
            req0 = r; row0 = t.row; col0 = t.col; data0 = t.data;
        end else begin
            req1 = r; row1 = t.row; col1 = t.col; data1 = t.data;
        end
    endtask

    // Port driver: holds each request until acked, optionally back-to-back.
    task automatic bfm(input int p);
        txn_t t;
        int   waited;
        logic got;
        forever begin
            @(posedge clk); #1;
            if (!rstn || n_todo[p] == 0 || int'($urandom_range(0, 99)) < gap_pct[p]) begin
                drive(p, 1'b0, '0);
                continue;
            end
            t.row  = 7'($urandom);
            t.col  = 2'($urandom);
            t.data = $urandom;
            drive(p, 1'b1, t);
            if (p == 0) q0.push_back(t); else q1.push_back(t);
            n_todo[p]--;
            got = 1'b0;
            waited = 0;
            while (!got && waited < 150) begin
                @(negedge clk);
                got = (p == 0) ? ack0 : ack1;
                waited++;
            end
            if (!got) begin
                chk("ack_timeout", 64'(p), 64'(p + 10));
                drive(p, 1'b0, '0);
                if (p == 0) q0.delete(); else q1.delete();
            end
        end
    endtask

    initial bfm(0);
    initial bfm(1);

    // Monitor: every strobe is checked against the scoreboard and the
    // arbitration rule (both requesting -> the port not granted last time).
    initial begin : monitor
        logic p_req0, p_req1, p_we, p_busy;
        logic [1:0] p_st;
        int   gp, ep, last_gnt;
        txn_t got_t, exp_t;
        p_req0 = 1'b0; p_req1 = 1'b0; p_we = 1'b0; p_busy = 1'b0; p_st = 2'd0;
        last_gnt = 1;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                last_gnt = 1;
                p_req0 = 1'b0; p_req1 = 1'b0; p_we = 1'b0; p_busy = 1'b0; p_st = 2'd0;
            end else begin
                if (we || ack0 || ack1) begin
                    gp = ack1 ? 1 : 0;
                    chk("strobe_shape", {62'd0, we, ack0 ^ ack1}, 64'd3);
                    ep = (p_req0 && p_req1) ? 1 - last_gnt : (p_req1 ? 1 : 0);
                    chk("arb_port", {62'd0, p_req0 | p_req1, gp[0]}, {62'd0, 1'b1, ep[0]});
                    chk("grant_window", {60'd0, p_st, p_we, p_busy}, 64'h4);
                    got_t = {o_row, o_col, o_data};
                    if ((gp == 0 && q0.size() == 0) || (gp == 1 && q1.size() == 0)) begin
                        chk("unexpected_write", 64'(gp), 64'(gp + 2));
                    end else begin
                        if (gp == 0) exp_t = q0.pop_front();
                        else         exp_t = q1.pop_front();
                        chk("payload", 64'(got_t), 64'(exp_t));
                    end
                    last_gnt = gp;
                    ack_cnt++;
                end
                p_req0 = req0; p_req1 = req1; p_we = we; p_busy = busy; p_st = status;
            end
        end
    end

    task automatic set_status(input logic [1:0] s);
        @(posedge clk); #1;
        status = s;
    endtask

    task automatic pulse_flush();
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((n_todo[0] != 0 || n_todo[1] != 0 || q0.size() != 0 || q1.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(n < budget), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_refresh(input logic lvl, input int budget, input string name);
        int n = 0;
        while (refresh !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(refresh), 64'(lvl));
    endtask

    task automatic count_refresh(input int cycles, output int seen);
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (refresh) seen++;
        end
    endtask

    // Drives the controller through BUSY/FINISH/READY, issuing flushes mid-refresh.
    task automatic service_refresh(input logic [15:0] exp_frame, input int n_flush);
        set_status(2'd2);
        repeat (2) @(negedge clk);
        for (int i = 0; i < n_flush; i++) pulse_flush();
        chk("refresh_hold", 64'(refresh), 64'd1);
        set_status(2'd3);
        repeat (2) @(negedge clk);
        chk("refresh_fall", 64'(refresh), 64'd0);
        chk("drain_busy", 64'(busy), 64'd1);
        set_status(2'd1);
        repeat (2) @(negedge clk);
        chk("frame_cnt", 64'(frame), 64'(exp_frame));
        chk("back_idle", 64'(busy), 64'd0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int seen;
        int base;
        n_todo[0] = 0; n_todo[1] = 0;
        gap_pct[0] = 0; gap_pct[1] = 0;

        repeat (3) @(negedge clk);
        chk("rst_ack0", 64'(ack0), 64'd0);
        chk("rst_ack1", 64'(ack1), 64'd0);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_refresh", 64'(refresh), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame", 64'(frame), 64'd0);
        chk("rst_payload", 64'({o_row, o_col, o_data}), 64'd0);

        // Requests must stall while the controller is still initialising.
        @(posedge clk); #1;
        rstn = 1'b1;
        n_todo[0] = 1;
        repeat (10) @(negedge clk);
        chk("ack_while_init", 64'(ack_cnt), 64'd0);
        chk("busy_in_wait_init", 64'(busy), 64'd1);
        set_status(2'd1);
        wait_drain(50);
        chk("first_write_acks", 64'(ack_cnt), 64'd1);

`ifdef LCD_SCHED_AUTOREFRESH_EN
        wait_refresh(1'b1, 110, "auto_refresh_rise");
        service_refresh(16'd1, 0);
        count_refresh(1000, seen);
        chk("auto_refresh_clean", 64'(seen), 64'd0);
`else
        // Both ports saturating: strict alternation with one idle cycle.
        base = ack_cnt;
        n_todo[0] = 8; n_todo[1] = 8;
        wait_drain(200);
        chk("both_acks", 64'(ack_cnt - base), 64'd16);

        // Random traffic with the controller status wandering.
        gap_pct[0] = 40; gap_pct[1] = 40;
        n_todo[0] = 30; n_todo[1] = 30;
        for (int c = 0; c < 250; c++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 15)      set_status(2'd1);
            else if (r < 17) set_status(2'd2);
            else if (r < 19) set_status(2'd3);
            else             set_status(2'd0);
        end
        set_status(2'd1);
        wait_drain(500);
        chk("no_refresh_random", 64'(frame), 64'd0);

        // Flush while port 0 keeps writing: refresh wins the next slot.
        gap_pct[0] = 0;
        n_todo[0] = 12;
        repeat (6) @(negedge clk);
        pulse_flush();
        repeat (2) @(negedge clk);
        chk("refresh_before_write", 64'(refresh), 64'd1);
        chk("no_write_at_refresh", 64'(we), 64'd0);
        service_refresh(16'd1, 0);
        wait_drain(200);
        chk("frame_after_writes", 64'(frame), 64'd1);

        // Asynchronous reset during a refresh, with another flush pending.
        pulse_flush();
        wait_refresh(1'b1, 5, "refresh_rise2");
        pulse_flush();
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_refresh", 64'(refresh), 64'd0);
        chk("async_rst_frame", 64'(frame), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_we", 64'({we, ack0, ack1}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        count_refresh(20, seen);
        chk("pending_cleared_by_reset", 64'(seen), 64'd0);

        // Three flushes during one refresh collapse into one extra refresh.
        pulse_flush();
        wait_refresh(1'b1, 5, "refresh_rise3");
        service_refresh(16'd1, 3);
        wait_refresh(1'b1, 5, "extra_refresh");
        service_refresh(16'd2, 0);
        count_refresh(50, seen);
        chk("single_extra", 64'(seen), 64'd0);

        // Without the timer a dirty frame never refreshes by itself.
        n_todo[1] = 1;
        wait_drain(50);
        count_refresh(300, seen);
        chk("no_auto_refresh", 64'(seen), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
